// File: rtl/mult_div_ctrl_if.sv
// rtl/mult_div_ctrl_if.sv - request/result bundle for the multiply/divide sequencer
interface mult_div_ctrl_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - iterative signed 32x32 MULT/DIV sequencer; MDC_DIVZERO_EXC_EN enables the divide-by-zero fast path
module mult_div_ctrl (
  input  logic            clk,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  // acc holds the upper product half (MULT) or the partial remainder (DIV)
  logic [32:0] acc_q, acc_d;
  // shr holds the multiplier being consumed (MULT) or dividend/quotient bits (DIV)
  logic [31:0] shr_q, shr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
`ifdef MDC_DIVZERO_EXC_EN
  logic        dz_q, dz_d;
`endif

  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum, shifted, diff;
  logic        ge;
  logic [63:0] prod, prod_s;
  logic [31:0] quo_s, rem_s;

  assign mag_a = mag(a_q);
  assign mag_b = mag(b_q);

  // Next-state logic: latch on start, iterate in RUN, sign-fix and load results in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    shr_d   = shr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDC_DIVZERO_EXC_EN
    dz_d    = dz_q;
`endif

    add_sum = acc_q + (shr_q[0] ? {1'b0, mag_a} : 33'd0);
    shifted = {acc_q[31:0], shr_q[31]};
    ge      = (shifted >= {1'b0, mag_b});
    diff    = shifted - {1'b0, mag_b};

    prod    = {acc_q[31:0], shr_q};
    prod_s  = (a_q[31] ^ b_q[31]) ? (~prod + 64'd1) : prod;
    quo_s   = (a_q[31] ^ b_q[31]) ? (~shr_q + 32'd1) : shr_q;
    rem_s   = a_q[31] ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = 5'd0;
          acc_d   = 33'd0;
          shr_d   = bus.op ? mag(bus.a) : mag(bus.b);
          state_d = S_RUN;
`ifdef MDC_DIVZERO_EXC_EN
          // Zero divisor: RUN sees the flag on its first cycle and leaves at once,
          // so done lands two cycles after the start edge with hi/lo untouched
          dz_d    = bus.op && (bus.b == 32'd0);
`endif
        end
      end
      S_RUN: begin
`ifdef MDC_DIVZERO_EXC_EN
        if (dz_q) begin
          state_d = S_DONE;
        end else begin
`else
        begin
`endif
          if (!op_q) begin
            acc_d = {1'b0, add_sum[32:1]};
            shr_d = {add_sum[0], shr_q[31:1]};
          end else begin
            acc_d = ge ? diff : shifted;
            shr_d = {shr_q[30:0], ge};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!op_q) begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end else if (b_q == 32'd0) begin
          // Divide by zero without the fast path: all-ones quotient, dividend as remainder
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_s;
          lo_d = quo_s;
        end
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
`ifdef MDC_DIVZERO_EXC_EN
        dz_d    = 1'b0;
`endif
      end
    endcase
  end

  // State registers with synchronous reset overriding any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 33'd0;
      shr_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDC_DIVZERO_EXC_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      shr_q   <= shr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDC_DIVZERO_EXC_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MDC_DIVZERO_EXC_EN
  assign bus.div_zero = (state_q == S_DONE) && dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb/tb_mult_div_ctrl.sv - randomized self-checking bench for mult_div_ctrl
module tb_mult_div_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_ctrl_if bus();
  mult_div_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [31:0] model_hi = 32'd0, model_lo = 32'd0;
  logic [31:0] exp_hi, exp_lo;
  int          exp_cyc;
  logic        exp_dz;

  int          r_cyc;
  logic [31:0] r_hi, r_lo;
  logic        r_dz, r_busy_ok, r_done_after, r_busy_after;

  // Reference: plain signed arithmetic on 64-bit values
  function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, p, q, r;
    sx = 64'(signed'(x));
    sy = 64'(signed'(y));
    exp_dz  = 1'b0;
    exp_cyc = 34;
    if (!o) begin
      p = sx * sy;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (y == 32'd0) begin
`ifdef MDC_DIVZERO_EXC_EN
      exp_cyc = 2;
      exp_dz  = 1'b1;
      exp_hi  = model_hi;
      exp_lo  = model_lo;
`else
      exp_hi = x;
      exp_lo = 32'hFFFF_FFFF;
`endif
    end else begin
      q = sx / sy;
      r = sx % sy;
      exp_hi = r[31:0];
      exp_lo = q[31:0];
    end
  endfunction

  // Issue one request (called just after a falling edge) and measure the response
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input int glitch_cyc, input bit glitch_done);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
    r_cyc = -1; r_busy_ok = 1'b1; r_hi = 32'd0; r_lo = 32'd0; r_dz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!bus.busy) r_busy_ok = 1'b0;
      if (bus.done) begin
        r_cyc = c; r_hi = bus.hi; r_lo = bus.lo; r_dz = bus.div_zero;
        break;
      end
      if (c == glitch_cyc) begin
        bus.start = 1'b1; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (glitch_done) begin
      bus.start = 1'b1; bus.op = 1'($urandom); bus.a = $urandom; bus.b = 32'd5;
    end
    @(negedge clk);
    r_done_after = bus.done; r_busy_after = bus.busy;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: busy/done/dz=%b%b%b hi=%h lo=%h expected 000 0 0",
               bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_vectors();
    logic        ops [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] as  [4]  = '{32'h0000_0007, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4]  = '{32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ehi [4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000};
    logic [31:0] elo [4]  = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 0, 0);
      total++;
      if (r_cyc !== 34 || r_hi !== ehi[i] || r_lo !== elo[i] || r_dz !== 1'b0) begin
        bad++;
        $display("FAIL fixed_vec%0d: cyc=%0d hi=%h lo=%h dz=%b expected cyc=34 hi=%h lo=%h dz=0",
                 i, r_cyc, r_hi, r_lo, r_dz, ehi[i], elo[i]);
      end
      total++;
      if (r_busy_ok !== 1'b1 || r_done_after !== 1'b0 || r_busy_after !== 1'b0) begin
        bad++;
        $display("FAIL fixed_busy%0d: busy_ok=%b done_after=%b busy_after=%b expected 1 0 0",
                 i, r_busy_ok, r_done_after, r_busy_after);
      end
      model_hi = ehi[i]; model_lo = elo[i];
    end
  endtask

  task automatic test_div_zero();
    model(1'b1, 32'd100, 32'd7);
    run_op(1'b1, 32'd100, 32'd7, 0, 0);
    total++;
    if (r_hi !== exp_hi || r_lo !== exp_lo) begin
      bad++;
      $display("FAIL dz_prior: hi=%h lo=%h expected hi=%h lo=%h", r_hi, r_lo, exp_hi, exp_lo);
    end
    model_hi = exp_hi; model_lo = exp_lo;
    model(1'b1, 32'h1234_5678, 32'd0);
    run_op(1'b1, 32'h1234_5678, 32'd0, 0, 0);
    total++;
    if (r_cyc !== exp_cyc || r_dz !== exp_dz || r_hi !== exp_hi || r_lo !== exp_lo) begin
      bad++;
      $display("FAIL div_zero: cyc=%0d dz=%b hi=%h lo=%h expected cyc=%0d dz=%b hi=%h lo=%h",
               r_cyc, r_dz, r_hi, r_lo, exp_cyc, exp_dz, exp_hi, exp_lo);
    end
    total++;
    if (r_done_after !== 1'b0 || bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL dz_pulse: done_after=%b dz_after=%b expected 0 0", r_done_after, bus.div_zero);
    end
    model_hi = exp_hi; model_lo = exp_lo;
  endtask

  task automatic test_ignore_start();
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 10, 1);
    total++;
    if (r_cyc !== 34 || r_hi !== 32'h0000_0001 || r_lo !== 32'h0000_0000) begin
      bad++;
      $display("FAIL ignore_start: cyc=%0d hi=%h lo=%h expected cyc=34 hi=00000001 lo=00000000",
               r_cyc, r_hi, r_lo);
    end
    total++;
    if (r_busy_after !== 1'b0 || r_done_after !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done: busy_after=%b done_after=%b expected 0 0", r_busy_after, r_done_after);
    end
    model_hi = 32'h0000_0001; model_lo = 32'h0000_0000;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      logic        o;
      logic [31:0] x, y;
      o = 1'($urandom); x = $urandom; y = $urandom_range(1, 1000);
      model(o, x, y);
      run_op(o, x, y, 0, 0);
      total++;
      if (r_cyc !== exp_cyc || r_hi !== exp_hi || r_lo !== exp_lo) begin
        bad++;
        $display("FAIL back_to_back%0d: cyc=%0d hi=%h lo=%h expected cyc=%0d hi=%h lo=%h",
                 i, r_cyc, r_hi, r_lo, exp_cyc, exp_hi, exp_lo);
      end
      model_hi = exp_hi; model_lo = exp_lo;
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 24; i++) begin
      logic        o;
      logic [31:0] x, y;
      o = 1'($urandom);
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(1, 30);
      model(o, x, y);
      run_op(o, x, y, 0, 0);
      total++;
      if (r_cyc !== exp_cyc || r_hi !== exp_hi || r_lo !== exp_lo || r_dz !== exp_dz) begin
        bad++;
        $display("FAIL random%0d op=%b a=%h b=%h: cyc=%0d hi=%h lo=%h dz=%b expected cyc=%0d hi=%h lo=%h dz=%b",
                 i, o, x, y, r_cyc, r_hi, r_lo, r_dz, exp_cyc, exp_hi, exp_lo, exp_dz);
      end
      model_hi = exp_hi; model_lo = exp_lo;
    end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h7654_3210; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.hi != 32'd0 || bus.lo != 32'd0) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL abort_quiet: disturbed_cycles=%0d expected 0", seen_done);
    end
    model_hi = 32'd0; model_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
